// File: rtl/mem_write_sender_if.sv
// Valid/ready memory write channel (address, data and response) between the
// write-back sender (master) and the memory (slave).
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif
`ifndef WORD_SIZE_BIT
`define WORD_SIZE_BIT 32
`endif

interface mem_write_sender_if #(
  parameter int ADDR_W = `MEM_ADDR_SIZE,
  parameter int DATA_W = `WORD_SIZE_BIT
);
  logic [ADDR_W-1:0] mem_awaddr;
  logic              mem_awvalid;
  logic              mem_awready;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wvalid;
  logic              mem_wready;
  logic [1:0]        mem_bresp;
  logic              mem_bvalid;
  logic              mem_bready;

  modport master (
    output mem_awaddr, mem_awvalid, mem_wdata, mem_wvalid, mem_bready,
    input  mem_awready, mem_wready, mem_bresp, mem_bvalid
  );

  modport slave (
    input  mem_awaddr, mem_awvalid, mem_wdata, mem_wvalid, mem_bready,
    output mem_awready, mem_wready, mem_bresp, mem_bvalid
  );
endinterface

// File: rtl/mem_write_sender.sv
// Write-back buffer to memory write-channel sender, one write outstanding.
// Optional watchdog enabled by defining SENDER_TIMEOUT_EN.
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif
`ifndef WORD_SIZE_BIT
`define WORD_SIZE_BIT 32
`endif

module mem_write_sender #(
  parameter int ADDR_W         = `MEM_ADDR_SIZE,
  parameter int DATA_W         = `WORD_SIZE_BIT,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                send_wr_addr,
  input  logic [ADDR_W-1:0]   write_address,
  input  logic                send_wr_data,
  input  logic [DATA_W-1:0]   write_data,
  output logic                addr_done,
  output logic                done,
  mem_write_sender_if.master  mem,
  output logic                wr_err,
  output logic                timeout_err,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] awaddr_r, awaddr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic              awvalid_r, awvalid_s;
  logic              wvalid_r, wvalid_s;
  logic              bready_r, bready_s;
  logic              addr_done_r, addr_done_s;
  logic              done_r, done_s;
  logic              busy_r, busy_s;
  logic              wr_err_r, wr_err_s;
  logic              timeout_err_r, timeout_err_s;
  logic              aw_fire_s, w_fire_s, b_fire_s;
  logic              timeout_hit_s;

  assign aw_fire_s = awvalid_r & mem.mem_awready;
  assign w_fire_s  = wvalid_r & mem.mem_wready;
  assign b_fire_s  = bready_r & mem.mem_bvalid;

`ifdef SENDER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt_r;

  // Watchdog counter: zero outside a transfer, counts each cycle in SEND or RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_r <= '0;
    end else if ((state_r == SEND) || (state_r == RESP)) begin
      wd_cnt_r <= wd_cnt_r + CNT_W'(1);
    end else begin
      wd_cnt_r <= '0;
    end
  end

  assign timeout_hit_s = ((state_r == SEND) || (state_r == RESP)) &&
                         (wd_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog compiled out; the parameter is only referenced here.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_s       = state_r;
    awaddr_s      = awaddr_r;
    wdata_s       = wdata_r;
    awvalid_s     = awvalid_r;
    wvalid_s      = wvalid_r;
    bready_s      = bready_r;
    addr_done_s   = 1'b0;
    done_s        = 1'b0;
    wr_err_s      = wr_err_r;
    timeout_err_s = timeout_err_r;

    case (state_r)
      IDLE: begin
        if (send_wr_addr & send_wr_data) begin
          awaddr_s  = write_address;
          wdata_s   = write_data;
          awvalid_s = 1'b1;
          wvalid_s  = 1'b1;
          state_s   = SEND;
        end else begin
          state_s   = IDLE;
        end
      end
      SEND: begin
        if (timeout_hit_s) begin
          awvalid_s     = 1'b0;
          wvalid_s      = 1'b0;
          bready_s      = 1'b0;
          timeout_err_s = 1'b1;
          done_s        = 1'b1;
          state_s       = DONE;
        end else begin
          if (aw_fire_s) begin
            awvalid_s   = 1'b0;
            addr_done_s = 1'b1;
          end else begin
            awvalid_s   = awvalid_r;
          end
          if (w_fire_s) begin
            wvalid_s = 1'b0;
          end else begin
            wvalid_s = wvalid_r;
          end
          // Each channel is finished once its valid is low or fires this cycle.
          if ((~awvalid_r | aw_fire_s) & (~wvalid_r | w_fire_s)) begin
            bready_s = 1'b1;
            state_s  = RESP;
          end else begin
            state_s  = SEND;
          end
        end
      end
      RESP: begin
        if (timeout_hit_s) begin
          bready_s      = 1'b0;
          timeout_err_s = 1'b1;
          done_s        = 1'b1;
          state_s       = DONE;
        end else if (b_fire_s) begin
          bready_s = 1'b0;
          done_s   = 1'b1;
          wr_err_s = wr_err_r | (mem.mem_bresp != 2'b00);
          state_s  = DONE;
        end else begin
          state_s  = RESP;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        awvalid_s = 1'b0;
        wvalid_s  = 1'b0;
        bready_s  = 1'b0;
        state_s   = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset drops every valid at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      awaddr_r      <= '0;
      wdata_r       <= '0;
      awvalid_r     <= 1'b0;
      wvalid_r      <= 1'b0;
      bready_r      <= 1'b0;
      addr_done_r   <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
      wr_err_r      <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      awaddr_r      <= awaddr_s;
      wdata_r       <= wdata_s;
      awvalid_r     <= awvalid_s;
      wvalid_r      <= wvalid_s;
      bready_r      <= bready_s;
      addr_done_r   <= addr_done_s;
      done_r        <= done_s;
      busy_r        <= busy_s;
      wr_err_r      <= wr_err_s;
      timeout_err_r <= timeout_err_s;
    end
  end

  assign mem.mem_awaddr  = awaddr_r;
  assign mem.mem_awvalid = awvalid_r;
  assign mem.mem_wdata   = wdata_r;
  assign mem.mem_wvalid  = wvalid_r;
  assign mem.mem_bready  = bready_r;
  assign addr_done       = addr_done_r;
  assign done            = done_r;
  assign busy            = busy_r;
  assign wr_err          = wr_err_r;
  assign timeout_err     = timeout_err_r;

endmodule

// File: tb/tb_mem_write_sender.sv
// Directed bench for mem_write_sender: per-cycle vector table plus hand-written
// sequences for back-to-back buffering, reset mid-response and the watchdog.
module tb_mem_write_sender;

  logic        clk;
  logic        reset;
  logic        send_wr_addr, send_wr_data;
  logic [31:0] write_address, write_data;
  logic        addr_done, done, wr_err, timeout_err, busy;

  int checks   = 0;
  int failures = 0;

  mem_write_sender_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  mem_write_sender #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .send_wr_addr  (send_wr_addr),
    .write_address (write_address),
    .send_wr_data  (send_wr_data),
    .write_data    (write_data),
    .addr_done     (addr_done),
    .done          (done),
    .mem           (mem_if),
    .wr_err        (wr_err),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock cycle: inputs for the cycle and outputs expected in it.
  typedef struct {
    logic [1:0]  req;     // {send_wr_addr, send_wr_data}
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  mem;     // {awready, wready, bvalid}
    logic [1:0]  bresp;
    logic [6:0]  e_ctl;   // {awvalid, wvalid, bready, addr_done, done, busy, wr_err}
    logic [31:0] e_awaddr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic [1:0] req, input logic [31:0] addr,
                             input logic [31:0] data, input logic [2:0] m,
                             input logic [1:0] br, input logic [6:0] ctl,
                             input logic [31:0] ea, input logic [31:0] ed);
    vec_t r;
    r.req = req; r.addr = addr; r.data = data; r.mem = m; r.bresp = br;
    r.e_ctl = ctl; r.e_awaddr = ea; r.e_wdata = ed;
    return r;
  endfunction

  function automatic logic [6:0] ctl_now();
    return {mem_if.mem_awvalid, mem_if.mem_wvalid, mem_if.mem_bready,
            addr_done, done, busy, wr_err};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  logic [31:0] q_addr[$];
  logic [31:0] seen_addr[$];
  logic [31:0] seen_data[$];
  logic [31:0] exp_addr[3];
  logic [31:0] tmp;
  int          n_done, n_ad;
  logic        seen_bad;

  initial begin
    reset = 1'b1;
    send_wr_addr = 1'b0; send_wr_data = 1'b0;
    write_address = 32'h0; write_data = 32'h0;
    mem_if.mem_awready = 1'b0; mem_if.mem_wready = 1'b0;
    mem_if.mem_bvalid  = 1'b0; mem_if.mem_bresp  = 2'b00;

    #1;
    chk("reset_ctl", {57'd0, ctl_now()}, 64'd0);
    chk("reset_awaddr", {32'd0, mem_if.mem_awaddr}, 64'd0);
    chk("reset_wdata", {32'd0, mem_if.mem_wdata}, 64'd0);
    chk("reset_timeout_err", {63'd0, timeout_err}, 64'd0);

    // c0..c5 zero-wait write; c6..c15 staggered ready with early/bad response;
    // c16..c20 good write with sticky wr_err; c21..c23 single requests ignored.
    vecs.push_back(v(2'b11, 32'h10, 32'hDEADBEEF, 3'b110, 2'd0, 7'b0000000, 32'h0,  32'h0));
    vecs.push_back(v(2'b11, 32'h99, 32'h1111,     3'b110, 2'd0, 7'b1100010, 32'h10, 32'hDEADBEEF));
    vecs.push_back(v(2'b11, 32'h99, 32'h1111,     3'b110, 2'd0, 7'b0011010, 32'h10, 32'hDEADBEEF));
    vecs.push_back(v(2'b11, 32'h99, 32'h1111,     3'b111, 2'd0, 7'b0010010, 32'h10, 32'hDEADBEEF));
    vecs.push_back(v(2'b00, 32'h0,  32'h0,        3'b110, 2'd0, 7'b0000110, 32'h10, 32'hDEADBEEF));
    vecs.push_back(v(2'b00, 32'h0,  32'h0,        3'b110, 2'd0, 7'b0000000, 32'h10, 32'hDEADBEEF));
    vecs.push_back(v(2'b11, 32'h20, 32'hCAFEF00D, 3'b000, 2'd0, 7'b0000000, 32'h10, 32'hDEADBEEF));
    vecs.push_back(v(2'b11, 32'h21, 32'h0,        3'b011, 2'd2, 7'b1100010, 32'h20, 32'hCAFEF00D));
    vecs.push_back(v(2'b11, 32'h21, 32'h0,        3'b001, 2'd2, 7'b1000010, 32'h20, 32'hCAFEF00D));
    vecs.push_back(v(2'b11, 32'h21, 32'h0,        3'b000, 2'd0, 7'b1000010, 32'h20, 32'hCAFEF00D));
    vecs.push_back(v(2'b11, 32'h21, 32'h0,        3'b000, 2'd0, 7'b1000010, 32'h20, 32'hCAFEF00D));
    vecs.push_back(v(2'b11, 32'h21, 32'h0,        3'b100, 2'd0, 7'b1000010, 32'h20, 32'hCAFEF00D));
    vecs.push_back(v(2'b11, 32'h21, 32'h0,        3'b000, 2'd0, 7'b0011010, 32'h20, 32'hCAFEF00D));
    vecs.push_back(v(2'b11, 32'h21, 32'h0,        3'b001, 2'd2, 7'b0010010, 32'h20, 32'hCAFEF00D));
    vecs.push_back(v(2'b00, 32'h0,  32'h0,        3'b000, 2'd0, 7'b0000111, 32'h20, 32'hCAFEF00D));
    vecs.push_back(v(2'b00, 32'h0,  32'h0,        3'b000, 2'd0, 7'b0000001, 32'h20, 32'hCAFEF00D));
    vecs.push_back(v(2'b11, 32'h30, 32'h12345678, 3'b110, 2'd0, 7'b0000001, 32'h20, 32'hCAFEF00D));
    vecs.push_back(v(2'b00, 32'h0,  32'h0,        3'b110, 2'd0, 7'b1100011, 32'h30, 32'h12345678));
    vecs.push_back(v(2'b00, 32'h0,  32'h0,        3'b110, 2'd0, 7'b0011011, 32'h30, 32'h12345678));
    vecs.push_back(v(2'b00, 32'h0,  32'h0,        3'b111, 2'd0, 7'b0010011, 32'h30, 32'h12345678));
    vecs.push_back(v(2'b00, 32'h0,  32'h0,        3'b110, 2'd0, 7'b0000111, 32'h30, 32'h12345678));
    vecs.push_back(v(2'b10, 32'h40, 32'h44,       3'b110, 2'd0, 7'b0000001, 32'h30, 32'h12345678));
    vecs.push_back(v(2'b01, 32'h40, 32'h44,       3'b110, 2'd0, 7'b0000001, 32'h30, 32'h12345678));
    vecs.push_back(v(2'b00, 32'h0,  32'h0,        3'b110, 2'd0, 7'b0000001, 32'h30, 32'h12345678));

    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      {send_wr_addr, send_wr_data} = vecs[i].req;
      write_address = vecs[i].addr;
      write_data    = vecs[i].data;
      {mem_if.mem_awready, mem_if.mem_wready, mem_if.mem_bvalid} = vecs[i].mem;
      mem_if.mem_bresp = vecs[i].bresp;
      #1;
      chk($sformatf("vec%0d_ctl", i), {57'd0, ctl_now()}, {57'd0, vecs[i].e_ctl});
      chk($sformatf("vec%0d_awaddr", i), {32'd0, mem_if.mem_awaddr}, {32'd0, vecs[i].e_awaddr});
      chk($sformatf("vec%0d_wdata", i), {32'd0, mem_if.mem_wdata}, {32'd0, vecs[i].e_wdata});
      @(posedge clk); #1;
    end

    // Back-to-back: buffer model pops on done at the negedge, memory with varying readies.
    q_addr = '{32'h100, 32'h204, 32'h308};
    exp_addr = '{32'h100, 32'h204, 32'h308};
    n_done = 0; n_ad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (addr_done) n_ad++;
      if (done) begin
        n_done++;
        if (q_addr.size() > 0) q_addr.delete(0);
      end
      if (q_addr.size() > 0) begin
        send_wr_addr = 1'b1; send_wr_data = 1'b1;
        write_address = q_addr[0]; write_data = ~q_addr[0];
      end else begin
        send_wr_addr = 1'b0; send_wr_data = 1'b0;
        write_address = 32'h0; write_data = 32'h0;
      end
      mem_if.mem_awready = ((c % 3) != 1);
      mem_if.mem_wready  = ((c % 2) == 0);
      mem_if.mem_bvalid  = mem_if.mem_bready;
      mem_if.mem_bresp   = 2'b00;
      // These handshakes complete at the coming posedge.
      if (mem_if.mem_awvalid && mem_if.mem_awready) seen_addr.push_back(mem_if.mem_awaddr);
      if (mem_if.mem_wvalid && mem_if.mem_wready) seen_data.push_back(mem_if.mem_wdata);
    end
    chk("b2b_done_count", 64'(n_done), 64'd3);
    chk("b2b_addr_done_count", 64'(n_ad), 64'd3);
    chk("b2b_aw_count", 64'(seen_addr.size()), 64'd3);
    chk("b2b_w_count", 64'(seen_data.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < seen_addr.size()) tmp = seen_addr[i]; else tmp = 32'hFFFF_FFFF;
      chk($sformatf("b2b_awaddr%0d", i), {32'd0, tmp}, {32'd0, exp_addr[i]});
      if (i < seen_data.size()) tmp = seen_data[i]; else tmp = 32'h0;
      chk($sformatf("b2b_wdata%0d", i), {32'd0, tmp}, {32'd0, ~exp_addr[i]});
    end
    chk("b2b_finish", {63'd0, (q_addr.size() == 0)}, 64'd1);
    chk("b2b_idle", {63'd0, busy}, 64'd0);

    // Reset while waiting for the response.
    @(negedge clk);
    send_wr_addr = 1'b1; send_wr_data = 1'b1;
    write_address = 32'h50; write_data = 32'h55;
    mem_if.mem_awready = 1'b1; mem_if.mem_wready = 1'b1; mem_if.mem_bvalid = 1'b0;
    for (int k = 0; k < 10 && !mem_if.mem_bready; k++) begin
      @(negedge clk);
      send_wr_addr = 1'b0; send_wr_data = 1'b0;
    end
    chk("rst_pre_bready", {63'd0, mem_if.mem_bready}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_ctl", {57'd0, ctl_now()}, 64'd0);
    chk("rst_awaddr", {32'd0, mem_if.mem_awaddr}, 64'd0);
    chk("rst_wdata", {32'd0, mem_if.mem_wdata}, 64'd0);
    chk("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
    seen_bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) reset = 1'b0;
      if (done || busy) seen_bad = 1'b1;
    end
    chk("rst_no_done", {63'd0, seen_bad}, 64'd0);

    // Address channel never ready: watchdog aborts (when built in) or the block waits.
    @(negedge clk);
    send_wr_addr = 1'b1; send_wr_data = 1'b1;
    write_address = 32'h60; write_data = 32'h66;
    mem_if.mem_awready = 1'b0; mem_if.mem_wready = 1'b1; mem_if.mem_bvalid = 1'b0;
    @(negedge clk);
    send_wr_addr = 1'b0; send_wr_data = 1'b0;
`ifdef SENDER_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("to_wait%0d", k), {60'd0, done, addr_done, timeout_err, busy}, 64'h1);
      @(negedge clk);
    end
    chk("to_abort", {57'd0, ctl_now()}, {57'd0, 7'b0000110});
    chk("to_err_set", {63'd0, timeout_err}, 64'd1);
    @(negedge clk);
    chk("to_idle", {60'd0, done, addr_done, timeout_err, busy}, 64'h2);
`else
    for (int k = 1; k <= 20; k++) begin
      chk($sformatf("nto_wait%0d", k),
          {59'd0, mem_if.mem_awvalid, done, addr_done, timeout_err, busy}, 64'h11);
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    chk("nto_reset_idle", {57'd0, ctl_now()}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_write_sender.md
# mem_write_sender

Write-channel sender sitting directly downstream of the write-back buffer. It takes one buffered word at a time (address plus data), drives it onto a valid/ready memory write interface (address, data and response channels), and returns `addr_done` and `done` pulses so the buffer can retire the entry. It keeps at most one write outstanding and is the only path from the write-back buffer to memory.

## Interface
Parameters:
- `ADDR_W`, default `` `MEM_ADDR_SIZE ``: address width.
- `DATA_W`, default `` `WORD_SIZE_BIT ``: data word width.
- `TIMEOUT_CYCLES`, default 255: watchdog limit. Used only with `SENDER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `send_wr_addr`  in  1  buffer presents a valid address.
- `write_address`  in  ADDR_W  buffer head address.
- `send_wr_data`  in  1  buffer presents valid data.
- `write_data`  in  DATA_W  buffer head data.
- `addr_done`  out  1  one-cycle pulse: address accepted by memory.
- `done`  out  1  one-cycle pulse: write complete (or aborted); buffer pops its head entry.
- `mem_awaddr`  out  ADDR_W  memory write address.
- `mem_awvalid`  out  1  address valid.
- `mem_awready`  in  1  memory accepts address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_wvalid`  out  1  data valid.
- `mem_wready`  in  1  memory accepts data.
- `mem_bresp`  in  2  write response; 0 means OK.
- `mem_bvalid`  in  1  response valid.
- `mem_bready`  out  1  sender ready for the response.
- `wr_err`  out  1  sticky; set when a response is nonzero.
- `timeout_err`  out  1  sticky; watchdog expired.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SEND, RESP, DONE.
- **IDLE:** when `send_wr_addr & send_wr_data` are both high at a posedge:
  - capture `write_address` and `write_data` into internal registers;
  - set `mem_awvalid` and `mem_wvalid` to 1;
  - go to SEND.
  - Either request alone is ignored.
- **SEND:** the address and data channels complete independently.
  - `mem_awvalid & mem_awready` → clear `mem_awvalid` and register an `addr_done` pulse for the next cycle.
  - `mem_wvalid & mem_wready` → clear `mem_wvalid`.
  - When both handshakes have completed (same cycle allowed) → RESP with `mem_bready` = 1.
- **RESP:** on `mem_bvalid & mem_bready`:
  - clear `mem_bready`;
  - register a `done` pulse for the next cycle;
  - if `mem_bresp` ≠ 0, set `wr_err`;
  - go to DONE.
  - `mem_bvalid` arriving before RESP is ignored because `mem_bready` is low.
- **DONE:** one cycle; `done` is high; go to IDLE.
  - The buffer updates on the negedge and drops its requests during this cycle, so the next posedge in IDLE does not re-capture the retired entry.
- Captured address and data are held constant while the valids are high. Input changes after capture, including `send_wr_addr` falling after `addr_done`, have no effect.
- `addr_done` and `done` are never high in the same cycle. `done` follows `addr_done` by at least 1 cycle.
- `wr_err` and `timeout_err` clear only on reset.

## Timing
- Reset, asynchronous and immediate:
  - state IDLE;
  - `mem_awvalid`, `mem_wvalid`, `mem_bready`, `addr_done`, `done`, `busy`, `wr_err`, `timeout_err` all 0;
  - `mem_awaddr` and `mem_wdata` 0.
- Reset during SEND or RESP drops all valids in the same cycle. No `done` pulse is issued.
- Latency, zero-wait memory (ready held high, `mem_bvalid` returned one cycle after `mem_bready`):
  - posedge 0: capture;
  - cycle 1: valids high, both handshakes complete;
  - cycle 2: `addr_done` high, RESP entered;
  - cycle 3: response handshake completes;
  - cycle 4: `done` high.
  - Minimum 4 cycles per word.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- Macro `SENDER_TIMEOUT_EN`.
- **Defined:**
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering SEND and increments each cycle in SEND or RESP.
  - On reaching TIMEOUT_CYCLES, all valids and `mem_bready` drop, `timeout_err` is set, and the block goes to DONE, pulsing `done` so the buffer cannot deadlock.
  - If `mem_awaddr` was never accepted, no `addr_done` is issued.
- **Undefined:** no counter; the block waits indefinitely in SEND or RESP; `timeout_err` is tied to 0.

## Test plan
- Zero-wait write: addr 0x10, data 0xDEADBEEF, requests high at posedge 0 → `addr_done` at cycle 2, `done` at cycle 4, `mem_awaddr`/`mem_wdata` match, `wr_err` = 0.
- Staggered ready: `mem_wready` high at cycle 1, `mem_awready` delayed to cycle 5 → `mem_bready` first high at cycle 6, `addr_done` at cycle 6, `done` ≥ cycle 7, data unchanged throughout.
- Early/erroneous response: `mem_bvalid` high in SEND is ignored; a later `mem_bresp` = 2 in RESP → `done` pulses and `wr_err` sets and stays 1 through subsequent good writes.
- Back-to-back with the write-back buffer: 3 entries queued → exactly 3 `done` pulses, memory sees the 3 addresses in FIFO order, no duplicates, buffer `finish` = 1 at the end.
- Reset mid-RESP: assert `reset` while `mem_bready` = 1 → all outputs 0 immediately, `busy` = 0, no `done` pulse.
- With `SENDER_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8: `mem_awready` held 0 → `timeout_err` = 1 and a `done` pulse after 8 cycles in SEND, no `addr_done`.
